// File: rtl/gpu_seg_mmu_if.sv
// gpu_seg_mmu_if: request/response handshake bundle for the segment MMU.
//   master (requester): drives i_valid, i_ctx, i_virtual_addr, i_ready
//   slave  (MMU)      : drives o_ready, o_valid, o_physical_addr, o_error, o_fault_code
interface gpu_seg_mmu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int CW         = 1
);
   logic                  i_valid;
   logic                  o_ready;
   logic [CW-1:0]         i_ctx;
   logic [ADDR_WIDTH-1:0] i_virtual_addr;
   logic                  o_valid;
   logic                  i_ready;
   logic [ADDR_WIDTH-1:0] o_physical_addr;
   logic                  o_error;
   logic [1:0]            o_fault_code;
   modport master (
      output i_valid, i_ctx, i_virtual_addr, i_ready,
      input  o_ready, o_valid, o_physical_addr, o_error, o_fault_code
   );
   modport slave (
      input  i_valid, i_ctx, i_virtual_addr, i_ready,
      output o_ready, o_valid, o_physical_addr, o_error, o_fault_code
   );
endinterface

// File: rtl/gpu_seg_mmu.sv
// gpu_seg_mmu: per-context segment table translating virtual to physical addresses, 1-cycle latency.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : valid/ready request in, valid/ready response out with fault code
//   cfg_*           : segment-table write port (base, bound, enable per ctx/segment)
//   i_fault_clr     : clears the first-fault log
//   o_fault_sticky/o_fault_addr/o_fault_count : first-fault log and saturating fault counter
module gpu_seg_mmu #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SEGS   = 4,
   parameter int NUM_CTX    = 2,
   parameter int FCNT_WIDTH = 8,
   localparam int SW = $clog2(NUM_SEGS),
   localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   gpu_seg_mmu_if.slave          bus,
   input  logic                  cfg_we,
   input  logic [CW-1:0]         cfg_ctx,
   input  logic [SW-1:0]         cfg_seg,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [ADDR_WIDTH-1:0] cfg_bound,
   input  logic                  cfg_en,
   input  logic                  i_fault_clr,
   output logic                  o_fault_sticky,
   output logic [ADDR_WIDTH-1:0] o_fault_addr,
   output logic [FCNT_WIDTH-1:0] o_fault_count
);
   // table is sized for the full ctx index space; out-of-range contexts are rejected before lookup
   localparam int DEPTH = (1 << CW) * NUM_SEGS;
   localparam logic [CW:0] CTX_LIM = (CW+1)'(NUM_CTX);
   logic [ADDR_WIDTH-1:0] r_base  [DEPTH];
   logic [ADDR_WIDTH-1:0] r_bound [DEPTH];
   logic [DEPTH-1:0]      r_en;
   logic                  r_valid, r_error;
   logic [1:0]            r_code;
   logic [ADDR_WIDTH-1:0] r_pa;
   logic [CW+SW-1:0]      w_idx, w_cfg_idx;
   logic [ADDR_WIDTH-1:0] w_off, w_pa;
   logic [1:0]            w_code;
   logic                  w_acc, w_fault;
   assign bus.o_ready         = !r_valid || bus.i_ready;
   assign bus.o_valid         = r_valid;
   assign bus.o_physical_addr = r_pa;
   assign bus.o_error         = r_error;
   assign bus.o_fault_code    = r_code;
   always_comb begin
      w_idx     = {bus.i_ctx, bus.i_virtual_addr[ADDR_WIDTH-1 -: SW]};
      w_cfg_idx = {cfg_ctx, cfg_seg};
      w_off     = {{SW{1'b0}}, bus.i_virtual_addr[ADDR_WIDTH-SW-1:0]};
      w_code    = ({1'b0, bus.i_ctx} >= CTX_LIM || !r_en[w_idx]) ? 2'b01 :
                  (w_off >= r_bound[w_idx])                     ? 2'b10 : 2'b00;
      w_pa      = (w_code == 2'b00) ? r_base[w_idx] + w_off : '0;
      w_acc     = bus.i_valid && bus.o_ready;
      w_fault   = w_acc && (w_code != 2'b00);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_code  <= '0;
         r_pa    <= '0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_error <= (w_code != 2'b00);
         r_code  <= w_code;
         r_pa    <= w_pa;
      end else if (bus.i_ready) begin
         r_valid <= 1'b0;
      end
   end
   // non-blocking write: a lookup in the same cycle sees the old entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_base[k]  <= '0;
            r_bound[k] <= '0;
         end
         r_en <= '0;
      end else if (cfg_we) begin
         r_base[w_cfg_idx]  <= cfg_base;
         r_bound[w_cfg_idx] <= cfg_bound;
         r_en[w_cfg_idx]    <= cfg_en;
      end
   end
   // clear wins over the old log, but a fault loading in the same cycle is recorded as the first one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_fault_sticky <= 1'b0;
         o_fault_addr   <= '0;
         o_fault_count  <= '0;
      end else if (i_fault_clr) begin
         o_fault_sticky <= w_fault;
         o_fault_addr   <= w_fault ? bus.i_virtual_addr : '0;
         o_fault_count  <= FCNT_WIDTH'(w_fault);
      end else if (w_fault) begin
         if (!o_fault_sticky) begin
            o_fault_sticky <= 1'b1;
            o_fault_addr   <= bus.i_virtual_addr;
         end
         o_fault_count <= o_fault_count + FCNT_WIDTH'(o_fault_count != '1);
      end
   end
endmodule

// File: tb/tb_gpu_seg_mmu.sv
// tb_gpu_seg_mmu: directed and randomized checks of gpu_seg_mmu against a behavioural model.
module tb_gpu_seg_mmu;
   localparam int AW = 32;
   localparam int CW = 1;
   typedef struct packed {logic [1:0] code; logic [AW-1:0] pa;} rsp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_we = 1'b0;
   logic [CW-1:0] cfg_ctx = '0;
   logic [1:0] cfg_seg = '0;
   logic [AW-1:0] cfg_base = '0, cfg_bound = '0;
   logic cfg_en = 1'b0, i_fault_clr = 1'b0;
   logic o_fault_sticky;
   logic [AW-1:0] o_fault_addr;
   logic [7:0] o_fault_count;
   int checks = 0, failures = 0;
   logic [AW-1:0] m_base [2][4];
   logic [AW-1:0] m_bound [2][4];
   bit m_en [2][4];
   bit m_sticky;
   logic [AW-1:0] m_faddr;
   int m_fcnt;
   gpu_seg_mmu_if #(.ADDR_WIDTH(AW), .CW(CW)) bus ();
   gpu_seg_mmu #(.ADDR_WIDTH(AW), .NUM_SEGS(4), .NUM_CTX(2), .FCNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_seg(cfg_seg), .cfg_base(cfg_base),
      .cfg_bound(cfg_bound), .cfg_en(cfg_en), .i_fault_clr(i_fault_clr),
      .o_fault_sticky(o_fault_sticky), .o_fault_addr(o_fault_addr), .o_fault_count(o_fault_count)
   );
   always #5 clk = ~clk;

   function automatic logic [1:0] m_code(int ctx, logic [AW-1:0] va);
      int seg = int'(va >> 30);
      logic [AW-1:0] off = va & 32'h3FFF_FFFF;
      if (ctx >= 2 || !m_en[ctx][seg]) return 2'b01;
      if (off >= m_bound[ctx][seg]) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [AW-1:0] m_pa(int ctx, logic [AW-1:0] va);
      longint sum;
      if (m_code(ctx, va) != 2'b00) return '0;
      sum = longint'(m_base[ctx][int'(va >> 30)]) + longint'(va & 32'h3FFF_FFFF);
      return AW'(sum % (64'd1 << 32));
   endfunction

   task automatic m_fault(logic [AW-1:0] va);
      if (!m_sticky) begin
         m_sticky = 1'b1;
         m_faddr = va;
      end
      if (m_fcnt < 255) m_fcnt++;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      cfg_we = 1'b0;
      i_fault_clr = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      bus.i_ctx = '0;
      bus.i_virtual_addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 4; s++) begin
            m_base[c][s] = '0;
            m_bound[c][s] = '0;
            m_en[c][s] = 1'b0;
         end
      m_sticky = 1'b0;
      m_faddr = '0;
      m_fcnt = 0;
   endtask

   task automatic cfg_write(int ctx, int seg, logic [AW-1:0] base, logic [AW-1:0] bound, bit en);
      cfg_we = 1'b1;
      cfg_ctx = CW'(ctx);
      cfg_seg = 2'(seg);
      cfg_base = base;
      cfg_bound = bound;
      cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
      m_base[ctx][seg] = base;
      m_bound[ctx][seg] = bound;
      m_en[ctx][seg] = en;
   endtask

   task automatic req(int ctx, logic [AW-1:0] va);
      bus.i_valid = 1'b1;
      bus.i_ctx = CW'(ctx);
      bus.i_virtual_addr = va;
      @(negedge clk);
      bus.i_valid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
      checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
      checks++; if (bus.o_physical_addr !== '0 || bus.o_error !== 1'b0 || bus.o_fault_code !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", bus.o_physical_addr, bus.o_error, bus.o_fault_code); end
      checks++; if (o_fault_sticky !== 1'b0 || o_fault_addr !== '0 || o_fault_count !== 8'd0) begin failures++; $display("FAIL reset_log got=%b/%h/%0d exp=0", o_fault_sticky, o_fault_addr, o_fault_count); end
   endtask

   task automatic test_translate();
      apply_reset();
      cfg_write(0, 1, 32'h8000_0000, 32'h1000, 1'b1);
      req(0, 32'h4000_0010);
      checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL xlate_valid got=%b exp=1", bus.o_valid); end
      checks++; if (bus.o_physical_addr !== 32'h8000_0010 || bus.o_fault_code !== 2'b00 || bus.o_error !== 1'b0) begin failures++; $display("FAIL xlate_ok got=%h/%b exp=80000010/00", bus.o_physical_addr, bus.o_fault_code); end
      req(0, 32'h4000_0FFF);
      checks++; if (bus.o_physical_addr !== 32'h8000_0FFF || bus.o_fault_code !== 2'b00) begin failures++; $display("FAIL xlate_last got=%h/%b exp=80000fff/00", bus.o_physical_addr, bus.o_fault_code); end
      req(0, 32'h4000_1000);
      checks++; if (bus.o_fault_code !== 2'b10 || bus.o_error !== 1'b1 || bus.o_physical_addr !== '0 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL xlate_bound got=%b/%b/%h exp=10/1/0", bus.o_fault_code, bus.o_error, bus.o_physical_addr); end
      checks++; if (o_fault_sticky !== 1'b1 || o_fault_addr !== 32'h4000_1000 || o_fault_count !== 8'd1) begin failures++; $display("FAIL xlate_log got=%b/%h/%0d exp=1/40001000/1", o_fault_sticky, o_fault_addr, o_fault_count); end
   endtask

   task automatic test_disabled();
      apply_reset();
      req(0, 32'h8000_0100);
      checks++; if (bus.o_fault_code !== 2'b01 || bus.o_error !== 1'b1 || bus.o_physical_addr !== '0) begin failures++; $display("FAIL dis_code got=%b/%b/%h exp=01/1/0", bus.o_fault_code, bus.o_error, bus.o_physical_addr); end
      checks++; if (o_fault_addr !== 32'h8000_0100 || o_fault_count !== 8'd1) begin failures++; $display("FAIL dis_log1 got=%h/%0d exp=80000100/1", o_fault_addr, o_fault_count); end
      req(0, 32'h8000_0000);
      checks++; if (bus.o_fault_code !== 2'b01 || o_fault_addr !== 32'h8000_0100 || o_fault_count !== 8'd2) begin failures++; $display("FAIL dis_log2 got=%b/%h/%0d exp=01/80000100/2", bus.o_fault_code, o_fault_addr, o_fault_count); end
      cfg_write(1, 0, 32'h1234, 32'h0, 1'b1);
      req(1, 32'h0000_0000);
      checks++; if (bus.o_fault_code !== 2'b10) begin failures++; $display("FAIL bound_zero got=%b exp=10", bus.o_fault_code); end
      cfg_write(1, 0, 32'h1234, 32'h0, 1'b0);
      req(1, 32'h0000_0000);
      checks++; if (bus.o_fault_code !== 2'b01) begin failures++; $display("FAIL dis_priority got=%b exp=01", bus.o_fault_code); end
   endtask

   task automatic test_stall();
      apply_reset();
      cfg_write(0, 3, 32'hFFFF_FFF0, 32'h100, 1'b1);
      bus.i_ready = 1'b0;
      req(0, 32'hC000_0020);
      bus.i_valid = 1'b1;
      bus.i_virtual_addr = 32'hC000_0030;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_physical_addr !== 32'h0000_0010 || bus.o_fault_code !== 2'b00) begin failures++; $display("FAIL stall_hold%0d got=%b/%b/%h exp=1/0/00000010", i, bus.o_valid, bus.o_ready, bus.o_physical_addr); end
         @(negedge clk);
      end
      bus.i_ready = 1'b1;
      #1;
      checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", bus.o_ready); end
      @(negedge clk);
      bus.i_valid = 1'b0;
      checks++; if (bus.o_valid !== 1'b1 || bus.o_physical_addr !== 32'h0000_0020) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/00000020", bus.o_valid, bus.o_physical_addr); end
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL stall_dup got=%b exp=0", bus.o_valid); end
   endtask

   task automatic test_cfg_collision();
      apply_reset();
      cfg_write(0, 1, 32'h8000_0000, 32'h1000, 1'b1);
      cfg_we = 1'b1;
      cfg_ctx = '0;
      cfg_seg = 2'd1;
      cfg_base = 32'h9000_0000;
      cfg_bound = 32'h1000;
      cfg_en = 1'b1;
      req(0, 32'h4000_0010);
      cfg_we = 1'b0;
      checks++; if (bus.o_physical_addr !== 32'h8000_0010) begin failures++; $display("FAIL coll_old got=%h exp=80000010", bus.o_physical_addr); end
      req(0, 32'h4000_0010);
      checks++; if (bus.o_physical_addr !== 32'h9000_0010) begin failures++; $display("FAIL coll_new got=%h exp=90000010", bus.o_physical_addr); end
   endtask

   task automatic test_reset_saturate();
      apply_reset();
      cfg_write(0, 1, 32'h8000_0000, 32'h1000, 1'b1);
      bus.i_ready = 1'b0;
      req(0, 32'h4000_2000);
      checks++; if (bus.o_valid !== 1'b1 || bus.o_error !== 1'b1 || o_fault_sticky !== 1'b1) begin failures++; $display("FAIL pre_rst got=%b/%b/%b exp=1/1/1", bus.o_valid, bus.o_error, o_fault_sticky); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.o_valid !== 1'b0 || bus.o_error !== 1'b0 || bus.o_fault_code !== 2'b00 || bus.o_physical_addr !== '0) begin failures++; $display("FAIL async_rst_rsp got=%b/%b/%b/%h exp=0", bus.o_valid, bus.o_error, bus.o_fault_code, bus.o_physical_addr); end
      checks++; if (o_fault_sticky !== 1'b0 || o_fault_addr !== '0 || o_fault_count !== 8'd0) begin failures++; $display("FAIL async_rst_log got=%b/%h/%0d exp=0", o_fault_sticky, o_fault_addr, o_fault_count); end
      @(negedge clk);
      rst = 1'b0;
      bus.i_ready = 1'b1;
      #1;
      checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL post_rst got=%b/%b exp=1/0", bus.o_ready, bus.o_valid); end
      req(0, 32'h4000_0010);
      checks++; if (bus.o_fault_code !== 2'b01) begin failures++; $display("FAIL table_cleared got=%b exp=01", bus.o_fault_code); end
      bus.i_valid = 1'b1;
      for (int i = 0; i < 257; i++) begin
         bus.i_virtual_addr = 32'h8000_0000 + 32'(i);
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      checks++; if (o_fault_count !== 8'hFF || o_fault_addr !== 32'h4000_0010) begin failures++; $display("FAIL saturate got=%h/%h exp=ff/40000010", o_fault_count, o_fault_addr); end
      i_fault_clr = 1'b1;
      req(0, 32'h8000_0ABC);
      i_fault_clr = 1'b0;
      checks++; if (o_fault_sticky !== 1'b1 || o_fault_addr !== 32'h8000_0ABC || o_fault_count !== 8'd1) begin failures++; $display("FAIL clr_with_fault got=%b/%h/%0d exp=1/80000abc/1", o_fault_sticky, o_fault_addr, o_fault_count); end
      i_fault_clr = 1'b1;
      @(negedge clk);
      i_fault_clr = 1'b0;
      checks++; if (o_fault_sticky !== 1'b0 || o_fault_addr !== '0 || o_fault_count !== 8'd0) begin failures++; $display("FAIL clr_only got=%b/%h/%0d exp=0", o_fault_sticky, o_fault_addr, o_fault_count); end
   endtask

   function automatic logic [AW-1:0] rnd_bound();
      int sel = int'($urandom_range(0, 3));
      return (sel == 0) ? 32'h0 : (sel == 1) ? 32'h10 : (sel == 2) ? 32'h1000 : 32'($urandom);
   endfunction

   task automatic test_random();
      rsp_t q[$];
      rsp_t e;
      bit iv, ir, cw, clr, acc;
      int ctx, seg, sel;
      logic [AW-1:0] off, va;
      apply_reset();
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 4; s++)
            cfg_write(c, s, 32'($urandom), rnd_bound(), 1'($urandom_range(0, 3) != 0));
      for (int n = 0; n < 600; n++) begin
         checks++; if (bus.o_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.o_valid, q.size() != 0); end
         if (q.size() != 0) begin
            e = q[0];
            checks++; if (bus.o_physical_addr !== e.pa || bus.o_fault_code !== e.code || bus.o_error !== (e.code != 2'b00)) begin failures++; $display("FAIL rnd_rsp n=%0d got=%h/%b exp=%h/%b", n, bus.o_physical_addr, bus.o_fault_code, e.pa, e.code); end
         end
         checks++; if (o_fault_sticky !== m_sticky || o_fault_addr !== m_faddr || o_fault_count !== 8'(m_fcnt)) begin failures++; $display("FAIL rnd_log n=%0d got=%b/%h/%0d exp=%b/%h/%0d", n, o_fault_sticky, o_fault_addr, o_fault_count, m_sticky, m_faddr, m_fcnt); end
         iv = $urandom_range(0, 3) != 0;
         ir = $urandom_range(0, 3) != 0;
         cw = $urandom_range(0, 7) == 0;
         clr = $urandom_range(0, 31) == 0;
         ctx = int'($urandom_range(0, 1));
         seg = int'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 3));
         off = (sel == 0) ? 32'($urandom_range(0, 32)) : (sel == 1) ? m_bound[ctx][seg] - 1 :
               (sel == 2) ? m_bound[ctx][seg] : 32'($urandom);
         va = (32'(seg) << 30) | (off & 32'h3FFF_FFFF);
         bus.i_valid = iv;
         bus.i_ready = ir;
         bus.i_ctx = CW'(ctx);
         bus.i_virtual_addr = va;
         i_fault_clr = clr;
         cfg_we = cw;
         cfg_ctx = CW'($urandom_range(0, 1));
         cfg_seg = 2'($urandom_range(0, 3));
         cfg_base = 32'($urandom);
         cfg_bound = rnd_bound();
         cfg_en = 1'($urandom_range(0, 3) != 0);
         #1;
         checks++; if (bus.o_ready !== (q.size() == 0 || ir)) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.o_ready, q.size() == 0 || ir); end
         acc = iv && (q.size() == 0 || ir);
         if (q.size() != 0 && ir) void'(q.pop_front());
         if (acc) q.push_back('{code: m_code(ctx, va), pa: m_pa(ctx, va)});
         if (clr) begin
            m_sticky = acc && m_code(ctx, va) != 2'b00;
            m_faddr = m_sticky ? va : '0;
            m_fcnt = m_sticky ? 1 : 0;
         end else if (acc && m_code(ctx, va) != 2'b00) m_fault(va);
         if (cw) begin
            m_base[int'(cfg_ctx)][int'(cfg_seg)] = cfg_base;
            m_bound[int'(cfg_ctx)][int'(cfg_seg)] = cfg_bound;
            m_en[int'(cfg_ctx)][int'(cfg_seg)] = cfg_en;
         end
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      cfg_we = 1'b0;
      i_fault_clr = 1'b0;
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      bus.i_ctx = '0;
      bus.i_virtual_addr = '0;
      test_reset();
      test_translate();
      test_disabled();
      test_stall();
      test_cfg_collision();
      test_reset_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gpu_seg_mmu.md
GPU_SEG_MMU -- requirements
Module: gpu_seg_mmu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning virtual/physical address width.
REQ-002 SHALL have parameter NUM_SEGS, default 4, meaning segments per context (power of two, >=2); SW = $clog2(NUM_SEGS).
REQ-003 SHALL have parameter NUM_CTX, default 2, meaning translation contexts; CW = max(1,$clog2(NUM_CTX)).
REQ-004 SHALL have parameter FCNT_WIDTH, default 8, meaning fault counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 cfg_we  in  1  segment-table write strobe.
REQ-009 cfg_ctx  in  CW  context being written.
REQ-010 cfg_seg  in  SW  segment being written.
REQ-011 cfg_base  in  ADDR_WIDTH  segment physical base.
REQ-012 cfg_bound  in  ADDR_WIDTH  segment size in bytes (exclusive limit on offset).
REQ-013 cfg_en  in  1  segment enable.
REQ-014 i_valid  in  1  request valid.
REQ-015 o_ready  out  1  request accepted when i_valid && o_ready.
REQ-016 i_ctx  in  CW  request context.
REQ-017 i_virtual_addr  in  ADDR_WIDTH  request virtual address.
REQ-018 o_valid  out  1  response valid.
REQ-019 i_ready  in  1  downstream accepts response.
REQ-020 o_physical_addr  out  ADDR_WIDTH  translated address.
REQ-021 o_error  out  1  response is a fault.
REQ-022 o_fault_code  out  2  00 none, 01 segment disabled, 10 bound violation.
REQ-023 o_fault_sticky, o_fault_addr (ADDR_WIDTH), o_fault_count (FCNT_WIDTH)  out  first-fault log; i_fault_clr  in  1  clears log.

Function
REQ-024 Segment index SHALL be i_virtual_addr[ADDR_WIDTH-1 -: SW]; offset SHALL be the remaining low bits zero-extended to ADDR_WIDTH.
REQ-025 Physical address SHALL be base + offset, truncated modulo 2^ADDR_WIDTH (wrap, no fault).
REQ-026 Fault priority: segment disabled (01) over offset >= bound (10); bound of 0 on enabled segment faults every access.
REQ-027 i_ctx >= NUM_CTX SHALL yield fault code 01.
REQ-028 On fault, o_error=1 and o_physical_addr SHALL be 0; response still delivered with o_valid=1.
REQ-029 o_ready SHALL equal !o_valid || i_ready (combinational).
REQ-030 Latency SHALL be exactly 1 cycle: accepted request appears on outputs the next cycle; back-to-back accepts give one response per cycle.
REQ-031 While o_valid && !i_ready, all response outputs SHALL hold stable.
REQ-032 Table lookup SHALL use pre-write contents when cfg_we targets the same entry in the accept cycle; write visible from the next accept.
REQ-033 cfg_we SHALL be honoured every cycle regardless of handshake state.
REQ-034 On loading a faulting response: if sticky=0, capture o_fault_addr=virtual address and set sticky; o_fault_count SHALL increment, saturating at all-ones.
REQ-035 i_fault_clr SHALL zero sticky, addr and count; if a fault loads in the same cycle, result SHALL be sticky=1, addr=that VA, count=1.

Reset
REQ-036 rst SHALL immediately clear o_valid, o_error, o_fault_code, o_physical_addr, sticky, fault addr, count, and all table entries (base=0, bound=0, en=0).
REQ-037 A request in flight at reset SHALL be discarded; o_ready=1 from first cycle after reset release.

Verification
REQ-038 Write ctx0 seg1 base=0x8000_0000 bound=0x1000 en=1; request ctx0 VA=0x4000_0010 -> next cycle o_valid=1, PA=0x8000_0010, code 00.
REQ-039 Same entry, VA=0x4000_1000 -> code 10, o_error=1, PA=0, sticky=1, fault_addr=0x4000_1000, count=1.
REQ-040 Request to unwritten seg2 after reset -> code 01; second fault VA=0x8000_0000 leaves fault_addr unchanged, count=2.
REQ-041 i_ready=0 for 3 cycles with continuous i_valid -> o_ready=0, outputs stable, no request lost or duplicated; base=0xFFFF_FFF0 offset 0x20 -> PA=0x0000_0010.
REQ-042 cfg_we to ctx0 seg1 (new base 0x9000_0000) same cycle as accept -> old PA; next request uses new base.
REQ-043 Assert rst mid-stall, then 257 faults with FCNT_WIDTH=8 -> all outputs zero during reset; count saturates at 0xFF; i_fault_clr with simultaneous fault -> count=1.
